// File: rtl/convolution.sv
// 3x3 spatial filter over an RGB565 column stream with one of four fixed kernels.
// Four register stages: window capture, products, 9-term sum, shift/clamp/output.
module convolution #(
  parameter int unsigned K_SELECT = 0,
  parameter int unsigned HRES     = 1280
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [2:0][15:0] data_in,
  input  logic [10:0]      hcount_in,
  input  logic [9:0]       vcount_in,
  input  logic             data_valid_in,
  output logic [15:0]      line_out,
  output logic [10:0]      hcount_out,
  output logic [9:0]       vcount_out,
  output logic             data_valid_out
);

  localparam int unsigned Shift = (K_SELECT == 1) ? 4 : 0;

  // Window: [row][col], col 0 newest, col 1 is the centre column.
  logic [2:0][2:0][15:0] win_q, win_d;
  logic [10:0]           hc1_q, hc1_d, hc2_q, hc2_d, hc3_q, hc3_d, hc4_q, hc4_d;
  logic [9:0]            vc1_q, vc1_d, vc2_q, vc2_d, vc3_q, vc3_d, vc4_q, vc4_d;
  logic                  v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
  logic [2:0][8:0][14:0] prod_q, prod_d;  // [channel][tap], channel 0 = R
  logic [2:0][18:0]      sum_q, sum_d;
  logic [15:0]           line_q, line_d;

  function automatic logic signed [7:0] coef(input int r, input int c);
    logic centre, ortho;
    centre = (r == 1) && (c == 1);
    ortho  = (r == 1) != (c == 1);
    case (K_SELECT)
      0:       coef = centre ? 8'sd1 : 8'sd0;
      1:       coef = centre ? 8'sd4 : (ortho ? 8'sd2 : 8'sd1);
      2:       coef = centre ? 8'sd5 : (ortho ? -8'sd1 : 8'sd0);
      default: coef = centre ? 8'sd8 : -8'sd1;
    endcase
  endfunction

  function automatic logic signed [14:0] tap(input int r, input int c, input logic [15:0] px,
                                             input int ch);
    logic signed [14:0] k, v;
    k = 15'(coef(r, c));
    case (ch)
      0:       v = 15'({1'b0, px[15:11]});
      1:       v = 15'({1'b0, px[10:5]});
      default: v = 15'({1'b0, px[4:0]});
    endcase
    return k * v;
  endfunction

  function automatic logic [18:0] sum9(input logic [8:0][14:0] p);
    logic signed [18:0] acc;
    acc = '0;
    for (int i = 0; i < 9; i++) begin
      acc = acc + 19'($signed(p[i]));
    end
    return acc;
  endfunction

  function automatic logic [5:0] clamp(input logic [18:0] s, input int ch);
    logic signed [18:0] sh, maxv;
    sh   = $signed(s) >>> Shift;
    maxv = (ch == 1) ? 19'sd63 : 19'sd31;
    if (sh < 0)         clamp = 6'd0;
    else if (sh > maxv) clamp = maxv[5:0];
    else                clamp = sh[5:0];
  endfunction

  always_comb begin
    win_d = win_q;
    if (data_valid_in) begin
      for (int r = 0; r < 3; r++) begin
        win_d[r][2] = win_q[r][1];
        win_d[r][1] = win_q[r][0];
        win_d[r][0] = data_in[r];
      end
    end
    // The window centre lags the newest column by one.
    hc1_d = (hcount_in == '0) ? 11'(HRES - 1) : hcount_in - 11'd1;
    vc1_d = vcount_in;
    v1_d  = data_valid_in;

    prod_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      for (int t = 0; t < 9; t++) begin
        prod_d[ch][t] = tap(t / 3, t % 3, win_q[t / 3][t % 3], ch);
      end
    end
    hc2_d = hc1_q;
    vc2_d = vc1_q;
    v2_d  = v1_q;

    sum_d = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum_d[ch] = sum9(prod_q[ch]);
    end
    hc3_d = hc2_q;
    vc3_d = vc2_q;
    v3_d  = v2_q;

    line_d = {5'(clamp(sum_q[0], 0)), 6'(clamp(sum_q[1], 1)), 5'(clamp(sum_q[2], 2))};
    hc4_d  = hc3_q;
    vc4_d  = vc3_q;
    v4_d   = v3_q;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      win_q  <= '0;
      hc1_q  <= '0;
      vc1_q  <= '0;
      v1_q   <= 1'b0;
      prod_q <= '0;
      hc2_q  <= '0;
      vc2_q  <= '0;
      v2_q   <= 1'b0;
      sum_q  <= '0;
      hc3_q  <= '0;
      vc3_q  <= '0;
      v3_q   <= 1'b0;
      line_q <= '0;
      hc4_q  <= '0;
      vc4_q  <= '0;
      v4_q   <= 1'b0;
    end else begin
      win_q  <= win_d;
      hc1_q  <= hc1_d;
      vc1_q  <= vc1_d;
      v1_q   <= v1_d;
      prod_q <= prod_d;
      hc2_q  <= hc2_d;
      vc2_q  <= vc2_d;
      v2_q   <= v2_d;
      sum_q  <= sum_d;
      hc3_q  <= hc3_d;
      vc3_q  <= vc3_d;
      v3_q   <= v3_d;
      line_q <= line_d;
      hc4_q  <= hc4_d;
      vc4_q  <= vc4_d;
      v4_q   <= v4_d;
    end
  end

  assign line_out       = line_q;
  assign hcount_out     = hc4_q;
  assign vcount_out     = vc4_q;
  assign data_valid_out = v4_q;

endmodule

// File: tb/tb_convolution.sv
// Drives the same column stream into all four kernel variants and checks each against
// a plain-arithmetic 3x3 filter model with a 3-edge output delay.
module tb_convolution;

  localparam int N = 2048;

  logic             clk_in = 1'b0;
  logic             rst_in;
  logic [2:0][15:0] data_in;
  logic [10:0]      hcount_in;
  logic [9:0]       vcount_in;
  logic             data_valid_in;

  logic [15:0] line_o  [4];
  logic [10:0] hcnt_o  [4];
  logic [9:0]  vcnt_o  [4];
  logic        valid_o [4];

  always #5 clk_in = ~clk_in;

  convolution #(.K_SELECT(0), .HRES(1280)) u_ident (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .data_valid_in(data_valid_in), .line_out(line_o[0]),
    .hcount_out(hcnt_o[0]), .vcount_out(vcnt_o[0]), .data_valid_out(valid_o[0]));
  convolution #(.K_SELECT(1), .HRES(1280)) u_gauss (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .data_valid_in(data_valid_in), .line_out(line_o[1]),
    .hcount_out(hcnt_o[1]), .vcount_out(vcnt_o[1]), .data_valid_out(valid_o[1]));
  convolution #(.K_SELECT(2), .HRES(1280)) u_sharp (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .data_valid_in(data_valid_in), .line_out(line_o[2]),
    .hcount_out(hcnt_o[2]), .vcount_out(vcnt_o[2]), .data_valid_out(valid_o[2]));
  convolution #(.K_SELECT(3), .HRES(1280)) u_ridge (
    .clk_in(clk_in), .rst_in(rst_in), .data_in(data_in), .hcount_in(hcount_in),
    .vcount_in(vcount_in), .data_valid_in(data_valid_in), .line_out(line_o[3]),
    .hcount_out(hcnt_o[3]), .vcount_out(vcnt_o[3]), .data_valid_out(valid_o[3]));

  int kern [4][9] = '{'{0, 0, 0, 0, 1, 0, 0, 0, 0},
                      '{1, 2, 1, 2, 4, 2, 1, 2, 1},
                      '{0, -1, 0, -1, 5, -1, 0, -1, 0},
                      '{-1, -1, -1, -1, 8, -1, -1, -1, -1}};
  int shf [4] = '{0, 4, 0, 0};

  logic [15:0] mw [3][3];  // model window [row][col], col 0 newest
  bit          rec_rst   [N];
  bit          rec_valid [N];
  logic [15:0] rec_line  [N][4];
  logic [10:0] rec_hc    [N];
  logic [9:0]  rec_vc    [N];

  int n_cyc = 0;
  int n_asserts = 0;
  int n_fail = 0;

  function automatic logic [15:0] ref_pixel(input int k);
    int acc [3];
    int res [3];
    int maxv;
    for (int ch = 0; ch < 3; ch++) acc[ch] = 0;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        acc[0] += kern[k][r * 3 + c] * int'(mw[r][c][15:11]);
        acc[1] += kern[k][r * 3 + c] * int'(mw[r][c][10:5]);
        acc[2] += kern[k][r * 3 + c] * int'(mw[r][c][4:0]);
      end
    end
    for (int ch = 0; ch < 3; ch++) begin
      maxv    = (ch == 1) ? 63 : 31;
      res[ch] = acc[ch] >>> shf[k];
      if (res[ch] < 0) res[ch] = 0;
      if (res[ch] > maxv) res[ch] = maxv;
    end
    return {5'(res[0]), 6'(res[1]), 5'(res[2])};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, n_cyc, obs, exp);
    end
  endtask

  task automatic check_outputs();
    bit zeroed = 1'b0;
    int j = n_cyc - 3;
    for (int i = n_cyc - 3; i <= n_cyc; i++) begin
      if (i < 0 || rec_rst[i]) zeroed = 1'b1;
    end
    for (int k = 0; k < 4; k++) begin
      if (zeroed) begin
        chk($sformatf("k%0d reset valid", k), 32'(valid_o[k]), 32'd0);
        chk($sformatf("k%0d reset line", k), 32'(line_o[k]), 32'd0);
        chk($sformatf("k%0d reset hcount", k), 32'(hcnt_o[k]), 32'd0);
        chk($sformatf("k%0d reset vcount", k), 32'(vcnt_o[k]), 32'd0);
      end else begin
        chk($sformatf("k%0d valid", k), 32'(valid_o[k]), 32'(rec_valid[j]));
        if (rec_valid[j]) begin
          chk($sformatf("k%0d line", k), 32'(line_o[k]), 32'(rec_line[j][k]));
          chk($sformatf("k%0d hcount", k), 32'(hcnt_o[k]), 32'(rec_hc[j]));
          chk($sformatf("k%0d vcount", k), 32'(vcnt_o[k]), 32'(rec_vc[j]));
        end
      end
    end
  endtask

  // One clock: drive a column, let the edge happen, update the model, check outputs.
  task automatic step(input logic [15:0] top, input logic [15:0] mid, input logic [15:0] bot,
                      input logic [10:0] hc, input logic [9:0] vc, input logic v,
                      input logic r);
    data_in[0]    = top;
    data_in[1]    = mid;
    data_in[2]    = bot;
    hcount_in     = hc;
    vcount_in     = vc;
    data_valid_in = v;
    rst_in        = r;
    @(posedge clk_in);
    if (r) begin
      for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) mw[a][b] = 16'h0000;
    end else if (v) begin
      for (int a = 0; a < 3; a++) begin
        mw[a][2] = mw[a][1];
        mw[a][1] = mw[a][0];
      end
      mw[0][0] = top;
      mw[1][0] = mid;
      mw[2][0] = bot;
    end
    rec_rst[n_cyc]   = r;
    rec_valid[n_cyc] = v && !r;
    rec_hc[n_cyc]    = (hc == 11'd0) ? 11'd1279 : hc - 11'd1;
    rec_vc[n_cyc]    = vc;
    for (int k = 0; k < 4; k++) rec_line[n_cyc][k] = ref_pixel(k);
    #1;
    check_outputs();
    n_cyc++;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(16'h0, 16'h0, 16'h0, 11'd0, 10'd0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [10:0] hc;
    logic        v;
    logic        r;
    for (int a = 0; a < 3; a++) for (int b = 0; b < 3; b++) mw[a][b] = 16'h0000;

    step(16'h0, 16'h0, 16'h0, 11'd0, 10'd0, 1'b0, 1'b1);
    step(16'h0, 16'h0, 16'h0, 11'd0, 10'd0, 1'b0, 1'b1);
    idle(2);

    // Identity pass-through of the centre column.
    step(16'h0000, 16'hA5A5, 16'h0000, 11'd0, 10'd5, 1'b1, 1'b0);
    step(16'h0000, 16'h1234, 16'h0000, 11'd1, 10'd5, 1'b1, 1'b0);
    step(16'h0000, 16'h0000, 16'h0000, 11'd2, 10'd5, 1'b1, 1'b0);
    idle(4);

    // Uniform white field: gaussian saturates back to white.
    for (int i = 0; i < 4; i++) step(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'(3 + i), 10'd6, 1'b1, 1'b0);

    // Dark centre among white neighbours, then the inverse.
    step(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'd10, 10'd7, 1'b1, 1'b0);
    step(16'hFFFF, 16'h0000, 16'hFFFF, 11'd11, 10'd7, 1'b1, 1'b0);
    step(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'd12, 10'd7, 1'b1, 1'b0);
    step(16'h0000, 16'h0000, 16'h0000, 11'd13, 10'd7, 1'b1, 1'b0);
    step(16'h0000, 16'hFFFF, 16'h0000, 11'd14, 10'd7, 1'b1, 1'b0);
    step(16'h0000, 16'h0000, 16'h0000, 11'd15, 10'd7, 1'b1, 1'b0);

    // Uniform mid-grey: ridge cancels to zero.
    for (int i = 0; i < 4; i++) step(16'h8410, 16'h8410, 16'h8410, 11'(20 + i), 10'd8, 1'b1, 1'b0);
    idle(3);

    // Valid gap and hcount wrap.
    step(16'h1111, 16'h2222, 16'h3333, 11'd0, 10'd9, 1'b1, 1'b0);
    step(16'h7777, 16'h7777, 16'h7777, 11'd5, 10'd9, 1'b0, 1'b0);
    step(16'h4444, 16'h5555, 16'h6666, 11'd1, 10'd9, 1'b1, 1'b0);
    step(16'h8888, 16'h9999, 16'hAAAA, 11'd2, 10'd9, 1'b1, 1'b0);
    idle(4);

    // Reset mid-stream, coinciding with a valid input.
    step(16'h1234, 16'h5678, 16'h9ABC, 11'd30, 10'd10, 1'b1, 1'b0);
    step(16'h4321, 16'h8765, 16'hCBA9, 11'd31, 10'd10, 1'b1, 1'b0);
    step(16'hDEAD, 16'hBEEF, 16'hF00D, 11'd32, 10'd10, 1'b1, 1'b1);
    step(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'd0, 10'd11, 1'b1, 1'b0);
    step(16'hFFFF, 16'hFFFF, 16'hFFFF, 11'd1, 10'd11, 1'b1, 1'b0);
    idle(4);

    // Random stream with gaps, line wraps and occasional resets.
    hc = 11'd1275;
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 59) == 0);
      step(16'($urandom), 16'($urandom), 16'($urandom), hc, 10'($urandom_range(0, 719)), v, r);
      if (v) hc = (hc == 11'd1279) ? 11'd0 : hc + 11'd1;
    end
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
